// File: rtl/qed_replay_buffer.sv
// Instruction replay buffer for QED: forwards and records originals in ORIG mode,
// then replays the recorded instructions in order as duplicates in DUP mode.
module qed_replay_buffer #(
    parameter int DEPTH = 16,
    parameter int IW    = 32,
    parameter int CW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exec_dup,
    input  logic                       in_valid,
    input  logic [IW-1:0]              in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [IW-1:0]              out_instr,
    output logic                       out_is_dup,
    input  logic                       out_ready,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CW-1:0]              num_orig,
    output logic [CW-1:0]              num_dup,
    output logic                       qed_ready,
    output logic                       dbg_mode
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    // Handshake: a transfer happens on any rising edge where valid && ready are
    // both high; out_valid/out_instr/out_is_dup hold steady while out_ready is low.

    typedef enum logic {
        ORIG = 1'b0,
        DUP  = 1'b1
    } mode_t;

    mode_t            mode, mode_next;
    logic [AW-1:0]    head, tail, head_next, tail_next;
    logic [CNTW-1:0]  count_next;
    logic [CW-1:0]    num_orig_next, num_dup_next;
    logic             qed_ready_next;
    logic             slot_free, accept, pop, full_next;
    logic [IW-1:0]    mem [DEPTH];

    assign full     = (count == CNTW'(DEPTH));
    assign empty    = (count == '0);
    assign dbg_mode = (mode == DUP);

    always_comb begin
        slot_free      = !out_valid || out_ready;
        in_ready       = (mode == ORIG) && !full && slot_free;
        accept         = in_valid && in_ready;
        pop            = (mode == DUP) && slot_free && !empty;

        count_next     = count;
        head_next      = head;
        tail_next      = tail;
        num_orig_next  = num_orig;
        num_dup_next   = num_dup;
        mode_next      = mode;

        // accept and pop are mutually exclusive because they live in different modes
        if (accept) begin
            count_next    = count + CNTW'(1);
            tail_next     = tail + AW'(1);
            num_orig_next = num_orig + CW'(1);
        end else if (pop) begin
            count_next    = count - CNTW'(1);
            head_next     = head + AW'(1);
            num_dup_next  = num_dup + CW'(1);
        end

        full_next = (count_next == CNTW'(DEPTH));

        case (mode)
            ORIG: if ((exec_dup || full_next) && count_next != '0) mode_next = DUP;
            DUP:  if (count_next == '0) mode_next = ORIG;
            default: mode_next = ORIG;
        endcase

        qed_ready_next = (num_orig_next == num_dup_next) && (num_orig_next != '0) &&
                         (mode_next == ORIG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= ORIG;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            num_orig  <= '0;
            num_dup   <= '0;
            qed_ready <= 1'b0;
        end else begin
            mode      <= mode_next;
            head      <= head_next;
            tail      <= tail_next;
            count     <= count_next;
            num_orig  <= num_orig_next;
            num_dup   <= num_dup_next;
            qed_ready <= qed_ready_next;
        end
    end

    // Storage is intentionally left unreset; only pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) mem[tail] <= in_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_is_dup <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_instr  <= in_instr;
            out_is_dup <= 1'b0;
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_instr  <= mem[head];
            out_is_dup <= 1'b1;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qed_replay_buffer.sv
// Directed bench for qed_replay_buffer: scoreboard of expected output beats plus
// hand-computed checks of counters, flags and mode around each scenario.
module tb_qed_replay_buffer;

    localparam int DEPTH = 16;
    localparam int IW    = 32;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          exec_dup;
    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic          in_ready;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic          out_is_dup;
    logic          out_ready;
    logic          full;
    logic          empty;
    logic [4:0]    count;
    logic [CW-1:0] num_orig;
    logic [CW-1:0] num_dup;
    logic          qed_ready;
    logic          dbg_mode;

    int tests = 0;
    int fails = 0;

    logic [IW:0]   exp_q[$];
    logic [IW-1:0] rec_q[$];

    qed_replay_buffer #(.DEPTH(DEPTH), .IW(IW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .exec_dup(exec_dup),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_is_dup(out_is_dup),
        .out_ready(out_ready), .full(full), .empty(empty), .count(count),
        .num_orig(num_orig), .num_dup(num_dup), .qed_ready(qed_ready),
        .dbg_mode(dbg_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output beats transfer on the next rising edge; sample them on the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", out_instr, 64'hDEAD);
            end else begin
                logic [IW:0] e;
                e = exp_q.pop_front();
                check("out_instr", out_instr, e[IW-1:0]);
                check("out_is_dup", out_is_dup, e[IW]);
            end
        end
    end

    task automatic push(input logic [IW-1:0] instr, input logic dup_req);
        in_valid = 1'b1;
        in_instr = instr;
        exec_dup = dup_req;
        check("in_ready", in_ready, 1'b1);
        exp_q.push_back({1'b0, instr});
        rec_q.push_back(instr);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exec_dup = 1'b0;
    endtask

    task automatic push_round(input logic [IW-1:0] base, input int n, input logic dup_last);
        for (int i = 0; i < n; i++) push(base + IW'(i), dup_last && (i == n - 1));
        while (rec_q.size() != 0) exp_q.push_back({1'b1, rec_q.pop_front()});
    endtask

    task automatic drain(input logic [CW-1:0] exp_n);
        int cyc = 0;
        while ((exp_q.size() != 0 || dbg_mode) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_timeout", (cyc >= 200), 1'b0);
        check("drain_num_orig", num_orig, exp_n);
        check("drain_num_dup", num_dup, exp_n);
        check("drain_qed_ready", qed_ready, 1'b1);
        check("drain_count", count, 0);
        check("drain_empty", empty, 1'b1);
    endtask

    initial begin
        rst = 1'b1; exec_dup = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_count", count, 0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_is_dup", out_is_dup, 1'b0);
        check("rst_num_orig", num_orig, 0);
        check("rst_num_dup", num_dup, 0);
        check("rst_qed_ready", qed_ready, 1'b0);
        check("rst_mode", dbg_mode, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // basic replay, exec_dup together with the third push
        push(32'h00A00093, 1'b0);
        push(32'h00B00113, 1'b0);
        push(32'h00C00193, 1'b1);
        while (rec_q.size() != 0) exp_q.push_back({1'b1, rec_q.pop_front()});
        check("basic_mode_dup", dbg_mode, 1'b1);
        check("basic_count", count, 3);
        check("basic_in_ready", in_ready, 1'b0);
        check("basic_qed_low", qed_ready, 1'b0);
        drain(16'd3);

        // exec_dup with nothing stored is ignored
        exec_dup = 1'b1;
        @(posedge clk); #1;
        exec_dup = 1'b0;
        check("empty_dup_mode", dbg_mode, 1'b0);
        check("empty_dup_in_ready", in_ready, 1'b1);
        check("empty_dup_count", count, 0);
        check("empty_dup_qed", qed_ready, 1'b1);

        // fill to DEPTH forces replay
        push_round(32'h1000_0000, DEPTH, 1'b0);
        check("full_flag", full, 1'b1);
        check("full_in_ready", in_ready, 1'b0);
        check("full_count", count, 16);
        check("full_mode", dbg_mode, 1'b1);
        drain(16'd19);

        // backpressure mid-replay
        push_round(32'h2000_0000, 4, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp_out_instr", out_instr, 32'h2000_0000);
            check("bp_out_is_dup", out_is_dup, 1'b1);
            check("bp_count", count, 3);
            check("bp_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        drain(16'd23);

        // reset after 2 of 5 duplicates
        push_round(32'h3000_0000, 5, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_count", count, 3);
        check("mid_num_dup", num_dup, 25);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("rr_count", count, 0);
        check("rr_out_valid", out_valid, 1'b0);
        check("rr_mode", dbg_mode, 1'b0);
        check("rr_num_orig", num_orig, 0);
        check("rr_num_dup", num_dup, 0);
        check("rr_qed_ready", qed_ready, 1'b0);
        check("rr_empty", empty, 1'b1);

        // pointer wrap: later rounds cross the wrap of head and tail
        push_round(32'h4000_0000, 5, 1'b1);
        drain(16'd5);
        push_round(32'h5000_0000, DEPTH, 1'b0);
        drain(16'd21);
        push_round(32'h6000_0000, DEPTH, 1'b0);
        drain(16'd37);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qed_replay_buffer.md
# qed_replay_buffer

Instruction replay buffer for the QED (quick error detection) front end of the picorv32 formal harness. In ORIG mode it passes fetched instructions downstream and records each one in a circular buffer. In DUP mode it stops accepting fetches and replays the recorded instructions in order as duplicates. It tracks original and duplicate counts and flags `qed_ready` when the counts match. It sits between the fetch/transform logic and the core's instruction input, and its post-reset state is all-zero: pointers, counters, mode and output valid.

## Interface

Parameters:
- `DEPTH`, 16: buffer entries. Must be a power of two, ≥ 2.
- `IW`, 32: instruction width.
- `CW`, 16: width of the orig/dup counters.

Ports:
- `clk`  in  1  clock. All logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `exec_dup`  in  1  request to switch to replay (DUP) mode.
- `in_valid`  in  1  fetched instruction valid.
- `in_instr`  in  IW  fetched (original-space) instruction.
- `in_ready`  out  1  buffer accepts `in_instr` this cycle.
- `out_valid`  out  1  `out_instr` valid.
- `out_instr`  out  IW  instruction to the core.
- `out_is_dup`  out  1  `out_instr` is a replayed duplicate.
- `out_ready`  in  1  core accepts `out_instr`.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `num_orig`  out  CW  originals issued since reset.
- `num_dup`  out  CW  duplicates issued since reset.
- `qed_ready`  out  1  `num_orig == num_dup`, `num_orig != 0`, and mode is ORIG.

## Operation

- **State:**
  - `mode` ∈ {ORIG, DUP}.
  - `head` and `tail` pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count` register.
  - Output register: `out_valid`, `out_instr`, `out_is_dup`.
- **Output slot free:** `slot_free = !out_valid || out_ready`.
- **ORIG mode:**
  - `in_ready = !full && slot_free`. This is a combinational output.
  - On an accept (`in_valid && in_ready`):
    - write `buf[tail]`; `tail++`; `count++`;
    - output register loads `in_instr` with `out_is_dup=0`;
    - `num_orig++`.
- **DUP mode:**
  - `in_ready = 0`.
  - When `slot_free && !empty`:
    - output register loads `buf[head]` with `out_is_dup=1`;
    - `head++`; `count--`; `num_dup++`.
- **Output register behaviour:**
  - With no load and `out_ready=1`, `out_valid` clears.
  - With `out_valid=1` and `out_ready=0`, all output fields hold unchanged.
- **Transitions:**
  - **ORIG→DUP:** when `(exec_dup || full_next) && count_next != 0`. `full_next` and `count_next` include this cycle's accept. An instruction accepted in the same cycle as `exec_dup` is therefore included in the replay.
  - **ORIG stays ORIG:** `exec_dup` with `count_next == 0` is ignored.
  - **DUP→ORIG:** the cycle after the pop that makes `count` 0. `exec_dup` is ignored in DUP.
- **Arithmetic:** `num_orig` and `num_dup` wrap modulo 2^CW. `qed_ready` uses the wrapped values.
- **Reset:**
  - Values: `mode=ORIG`, `head=tail=count=0`, `out_valid=0`, `out_instr=0`, `out_is_dup=0`, `num_orig=num_dup=0`, `qed_ready=0`.
  - Buffer contents are not reset.
  - Reset mid-replay discards all entries, and the in-flight output is dropped.
- **Full:** DEPTH accepts with no `exec_dup` force DUP; no input is lost, because `in_ready` is already 0 when `full`.

## Timing

- Input to output latency is 1 cycle: an instruction accepted at edge N shows `out_valid` after edge N.
- The mode change takes effect after the deciding edge. For the first DUP pop the earliest `out_is_dup=1` is 1 cycle after the switch edge.
- **Throughput:** 1 instruction/cycle in both modes while `out_ready=1`.
- `qed_ready` is registered and computed from next-state values, so it updates on the same edge as the counters.
- `full`, `empty` and `count` reflect registered state.

## Test plan

- **Basic replay:** reset; push 0x00A00093, 0x00B00113, 0x00C00193 with `out_ready=1`; pulse `exec_dup` with the third push → outputs are the three with `is_dup=0`, then the same three in order with `is_dup=1`; then mode returns to ORIG with `num_orig=num_dup=3` and `qed_ready=1`.
- **Full:** DEPTH=16; push 16 instructions with `exec_dup=0` → `full=1` and `in_ready=0` after the 16th; automatic DUP replays all 16; finishes with `count=0`, `empty=1`, `qed_ready=1`.
- **Backpressure:** hold `out_ready=0` for 3 cycles mid-replay → `out_instr` and `out_is_dup` stable and `head` unchanged; resuming produces no skipped or duplicated entries.
- **Empty exec_dup:** `exec_dup=1` with `count=0` and no input → mode stays ORIG and `in_ready` remains 1.
- **Reset mid-replay:** assert `rst` after 2 of 5 duplicates → next cycle has all counters/pointers 0, `out_valid=0`, mode ORIG.
- **Pointer wrap:** two full 16-entry fill/replay rounds plus a 5-entry round → data order preserved across the wrap of `head` and `tail`; `num_orig=num_dup=37`.
